// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: the $zero register, default widths and
// the layout of one commit-pipe stage record.
package mips_pipe_pkg;

    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam int         DEF_DATA_W = 32;
    localparam int         DEF_ADDR_W = 5;

    // The stage record at default widths; wider or narrower instances keep
    // the same {valid, rd, data} field order.
    typedef struct packed {
        logic                  valid;
        logic [DEF_ADDR_W-1:0] rd;
        logic [DEF_DATA_W-1:0] data;
    } stage_t;

endpackage

// File: rtl/wb_commit_if.sv
// MEM-to-WB commit bus: MEM-side write request, pipeline control,
// forwarding query and register-file write port.
interface wb_commit_if #(
    parameter int DATA_W = mips_pipe_pkg::DEF_DATA_W,
    parameter int ADDR_W = mips_pipe_pkg::DEF_ADDR_W,
    parameter int DEPTH  = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              mem_regwrite;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              pause;
    logic              flush;
    logic [ADDR_W-1:0] fwd_rs;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic              wb_regwrite;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic [CNT_W-1:0]  inflight;

    modport master (
        output mem_regwrite, mem_rd, mem_data, pause, flush, fwd_rs,
        input  fwd_hit, fwd_data, wb_regwrite, wb_rd, wb_data, inflight
    );

    modport slave (
        input  mem_regwrite, mem_rd, mem_data, pause, flush, fwd_rs,
        output fwd_hit, fwd_data, wb_regwrite, wb_rd, wb_data, inflight
    );
endinterface

// File: rtl/wb_commit_pipe_stage.sv
// One commit-pipe register stage: clear beats hold, hold beats load.
module wb_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold_i,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic [ADDR_W-1:0] rd_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] rd_o,
    output logic [DATA_W-1:0] data_o
);
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        data_d  = data_q;
        // rd/data are left alone on clear; they are masked while invalid
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (!hold_i) begin
            valid_d = valid_i;
            rd_d    = rd_i;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign rd_o    = rd_q;
    assign data_o  = data_q;
endmodule

// File: rtl/wb_commit_pipe.sv
// MEM/WB commit pipeline: DEPTH register stages carrying register writes to
// the register file, with pause, flush, $zero suppression and forwarding.
module wb_commit_pipe
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 2
) (
    input logic        clk,
    input logic        rst_n,
    wb_commit_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] ZERO_RD = ADDR_W'(REG_ZERO);

    logic [DEPTH-1:0]  st_valid;
    logic [ADDR_W-1:0] st_rd   [DEPTH];
    logic [DATA_W-1:0] st_data [DEPTH];
    logic [DEPTH-1:0]  ld_valid;
    logic [ADDR_W-1:0] ld_rd   [DEPTH];
    logic [DATA_W-1:0] ld_data [DEPTH];

    logic              fwd_hit_d;
    logic [DATA_W-1:0] fwd_data_d;
    logic [CNT_W-1:0]  inflight_d;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign ld_valid[gi] = bus.mem_regwrite && (bus.mem_rd != ZERO_RD);
                assign ld_rd[gi]    = bus.mem_rd;
                assign ld_data[gi]  = bus.mem_data;
            end else begin : g_body
                assign ld_valid[gi] = st_valid[gi-1];
                assign ld_rd[gi]    = st_rd[gi-1];
                assign ld_data[gi]  = st_data[gi-1];
            end

            wb_stage #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .hold_i  (bus.pause),
                .clear_i (bus.flush),
                .valid_i (ld_valid[gi]),
                .rd_i    (ld_rd[gi]),
                .data_i  (ld_data[gi]),
                .valid_o (st_valid[gi]),
                .rd_o    (st_rd[gi]),
                .data_o  (st_data[gi])
            );
        end
    endgenerate

    // Scan oldest to youngest so the youngest match is the last one assigned.
    always_comb begin
        fwd_hit_d  = 1'b0;
        fwd_data_d = '0;
        if (bus.fwd_rs != ZERO_RD) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (st_valid[i] && (st_rd[i] == bus.fwd_rs)) begin
                    fwd_hit_d  = 1'b1;
                    fwd_data_d = st_data[i];
                end
            end
        end
    end

    always_comb begin
        inflight_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            inflight_d = inflight_d + CNT_W'(st_valid[i]);
        end
    end

    // A paused tail entry stays put, so its write is deferred to avoid a double commit.
    assign bus.wb_regwrite = st_valid[DEPTH-1] && !bus.pause;
    assign bus.wb_rd       = st_valid[DEPTH-1] ? st_rd[DEPTH-1]   : '0;
    assign bus.wb_data     = st_valid[DEPTH-1] ? st_data[DEPTH-1] : '0;
    assign bus.fwd_hit     = fwd_hit_d;
    assign bus.fwd_data    = fwd_data_d;
    assign bus.inflight    = inflight_d;
endmodule

// File: tb/tb_wb_commit_pipe.sv
// Directed vector bench for wb_commit_pipe at DEPTH=2: table of per-cycle
// inputs with expected outputs, plus an asynchronous reset sequence.
module tb_wb_commit_pipe;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    wb_commit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    wb_commit_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        pause;
        logic        flush;
        logic [4:0]  fwd_rs;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic        e_hit;
        logic [31:0] e_fdata;
        logic [1:0]  e_inf;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_all(input string tag, input logic we, input logic [4:0] rd,
                             input logic [31:0] data, input logic hit,
                             input logic [31:0] fdata, input logic [1:0] inf);
        check({tag, ".wb_regwrite"}, 32'(bus.wb_regwrite), 32'(we));
        check({tag, ".wb_rd"},       32'(bus.wb_rd),       32'(rd));
        check({tag, ".wb_data"},     bus.wb_data,          data);
        check({tag, ".fwd_hit"},     32'(bus.fwd_hit),     32'(hit));
        check({tag, ".fwd_data"},    bus.fwd_data,         fdata);
        check({tag, ".inflight"},    32'(bus.inflight),    32'(inf));
    endtask

    task automatic drive(input logic rw, input logic [4:0] rd, input logic [31:0] data,
                         input logic p, input logic f, input logic [4:0] rs);
        bus.mem_regwrite = rw;
        bus.mem_rd       = rd;
        bus.mem_data     = data;
        bus.pause        = p;
        bus.flush        = f;
        bus.fwd_rs       = rs;
    endtask

    initial begin
        // Each row: inputs for the cycle, then outputs expected in that same
        // cycle (state left by earlier edges); the row's inputs are captured
        // at the following rising edge.
        //            rw    rd     data           p     f     rs    we    wrd    wdata          hit   fdata          inf
        vq.push_back('{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b0, 5'd5, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        2'd0}); // 0 latency
        vq.push_back('{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd5, 1'b0, 5'd0,  32'h0,        1'b1, 32'hDEADBEEF, 2'd1});
        vq.push_back('{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd5, 1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 2'd1});
        vq.push_back('{1'b1, 5'd0,  32'h1234,     1'b0, 1'b0, 5'd0, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        2'd0}); // 3 $zero
        vq.push_back('{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        2'd0});
        vq.push_back('{1'b1, 5'd7,  32'h11,       1'b0, 1'b0, 5'd7, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        2'd0}); // 5 same rd
        vq.push_back('{1'b1, 5'd7,  32'h22,       1'b0, 1'b0, 5'd7, 1'b0, 5'd0,  32'h0,        1'b1, 32'h11,       2'd1});
        vq.push_back('{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd7, 1'b1, 5'd7,  32'h11,       1'b1, 32'h22,       2'd2});
        vq.push_back('{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd7, 1'b1, 5'd7,  32'h22,       1'b1, 32'h22,       2'd1});
        vq.push_back('{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd7, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        2'd0});
        vq.push_back('{1'b1, 5'd9,  32'hA5A5,     1'b0, 1'b0, 5'd9, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        2'd0}); // 10 pause
        vq.push_back('{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd9, 1'b0, 5'd0,  32'h0,        1'b1, 32'hA5A5,     2'd1});
        vq.push_back('{1'b1, 5'd3,  32'h33,       1'b1, 1'b0, 5'd9, 1'b0, 5'd9,  32'hA5A5,     1'b1, 32'hA5A5,     2'd1});
        vq.push_back('{1'b1, 5'd3,  32'h33,       1'b1, 1'b0, 5'd9, 1'b0, 5'd9,  32'hA5A5,     1'b1, 32'hA5A5,     2'd1});
        vq.push_back('{1'b1, 5'd3,  32'h33,       1'b1, 1'b0, 5'd9, 1'b0, 5'd9,  32'hA5A5,     1'b1, 32'hA5A5,     2'd1});
        vq.push_back('{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd9, 1'b1, 5'd9,  32'hA5A5,     1'b1, 32'hA5A5,     2'd1});
        vq.push_back('{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd3, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        2'd0});
        vq.push_back('{1'b1, 5'd10, 32'hAA,       1'b0, 1'b0, 5'd0, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        2'd0}); // 17 pause+flush
        vq.push_back('{1'b1, 5'd11, 32'hBB,       1'b0, 1'b0, 5'd10,1'b0, 5'd0,  32'h0,        1'b1, 32'hAA,       2'd1});
        vq.push_back('{1'b1, 5'd12, 32'hCC,       1'b1, 1'b1, 5'd11,1'b0, 5'd10, 32'hAA,       1'b1, 32'hBB,       2'd2});
        vq.push_back('{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd11,1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        2'd0});
        vq.push_back('{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd12,1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        2'd0});
        vq.push_back('{1'b1, 5'd4,  32'h44,       1'b0, 1'b0, 5'd0, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        2'd0}); // 22 flush
        vq.push_back('{1'b1, 5'd6,  32'h66,       1'b0, 1'b1, 5'd4, 1'b0, 5'd0,  32'h0,        1'b1, 32'h44,       2'd1});
        vq.push_back('{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd6, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        2'd0});

        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
        repeat (2) @(negedge clk);
        #2;
        check_all("reset", 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 2'd0);
        $display("reset: wb_regwrite=%0b inflight=%0d", bus.wb_regwrite, bus.inflight);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].rw, vq[i].rd, vq[i].data, vq[i].pause, vq[i].flush, vq[i].fwd_rs);
            #2;
            check_all($sformatf("vec%0d", i), vq[i].e_we, vq[i].e_rd, vq[i].e_data,
                      vq[i].e_hit, vq[i].e_fdata, vq[i].e_inf);
            $display("vec %0d: in rw=%0b rd=%0d data=0x%0h p=%0b f=%0b rs=%0d | out we=%0b rd=%0d data=0x%0h hit=%0b fdata=0x%0h inf=%0d",
                     i, vq[i].rw, vq[i].rd, vq[i].data, vq[i].pause, vq[i].flush, vq[i].fwd_rs,
                     bus.wb_regwrite, bus.wb_rd, bus.wb_data, bus.fwd_hit, bus.fwd_data, bus.inflight);
        end

        // Asynchronous reset with two entries in flight, between clock edges.
        @(negedge clk);
        drive(1'b1, 5'd1, 32'h1, 1'b0, 1'b0, 5'd2);
        @(negedge clk);
        drive(1'b1, 5'd2, 32'h2, 1'b0, 1'b0, 5'd2);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd2);
        #2;
        check_all("pre_rst", 1'b1, 5'd1, 32'h1, 1'b1, 32'h2, 2'd2);
        #1 rst_n = 1'b0;
        #1;
        check_all("async_rst", 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 2'd0);
        $display("async reset: wb_regwrite=%0b fwd_hit=%0b inflight=%0d",
                 bus.wb_regwrite, bus.fwd_hit, bus.inflight);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        check_all("post_rst", 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 2'd0);
        @(negedge clk);
        #2;
        check_all("post_rst2", 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/wb_commit_pipe.md
# wb_commit_pipe

Parametrised MEM/WB commit pipeline carrying register-write control (write enable, destination register, write data) from the MEM stage to the register-file write port over a configurable number of clocked stages. Adds pipeline pause (hold), flush, $zero write suppression, and a forwarding lookup across all in-flight writes. Sits between the MEM stage and the register file. Replaces the fixed single-bit regwrite delay element.

## Interface
Parameters:
- DATA_W, 32, width of write data
- ADDR_W, 5, width of register address
- DEPTH, 2, number of register stages between MEM input and WB output; legal range 1..4

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- mem_regwrite  in  1  MEM stage requests a register write
- mem_rd  in  ADDR_W  destination register
- mem_data  in  DATA_W  write data
- pause  in  1  hold all stages this cycle
- flush  in  1  kill all in-flight writes this cycle
- fwd_rs  in  ADDR_W  forwarding query address
- fwd_hit  out  1  an in-flight write targets fwd_rs
- fwd_data  out  DATA_W  data of youngest matching in-flight write
- wb_regwrite  out  1  register-file write enable
- wb_rd  out  ADDR_W  register-file write address
- wb_data  out  DATA_W  register-file write data
- inflight  out  $clog2(DEPTH+1)  count of valid stages

## Operation
- Each stage k (0..DEPTH-1) holds valid, rd, data. Stage 0 is youngest; stage DEPTH-1 drives wb_*.
- Capture qualifier: valid_in = mem_regwrite && (mem_rd != 0). Writes to $zero never enter the pipe.
- Normal cycle (pause=0, flush=0): stage 0 <= {valid_in, mem_rd, mem_data}; stage k <= stage k-1.
- Pause (pause=1, flush=0): all stages hold; input is not captured (the upstream stage holds it).
- Flush (flush=1): every stage valid <= 0, regardless of pause; input that cycle is dropped. rd/data are don't-care when valid=0.
- wb_regwrite = valid[DEPTH-1] && !pause. Gated during pause so a held entry is never written twice. wb_rd/wb_data are stage DEPTH-1 fields, driven 0 when valid=0.
- Forwarding (combinational): scan stages 0..DEPTH-1. The youngest valid stage with rd == fwd_rs wins. fwd_hit=0 when fwd_rs==0 or no match; fwd_data=0 when fwd_hit=0.
- inflight = popcount of stage valid bits.

## Timing
- Reset (rst_n low, asynchronous): all valid=0, rd=0, data=0. Hence wb_regwrite=0, wb_rd=0, wb_data=0, fwd_hit=0, fwd_data=0, inflight=0. Release is synchronous to the next clk edge.
- Latency: a write presented at edge N appears on wb_* after edge N+DEPTH-1 (visible in cycle N+DEPTH-1 to N+DEPTH) when unpaused. Each pause cycle adds one.
- Forwarding reflects stage state in the same cycle; it does not see the current mem_* input.
- Simultaneous pause+flush: flush wins.
- Reset mid-pause or mid-flush: reset wins immediately.
- Back-to-back writes to the same rd: both commit in order; forwarding returns the younger one.
- Throughput: one write per unpaused cycle; no bubbles are inserted.

## Structure
- Shared package mips_pipe_pkg holds REG_ZERO (5'd0), the default DATA_W/ADDR_W, and the stage record layout {valid, rd, data}.
- One sub-module, wb_stage: a single register stage with hold/clear/load, instantiated DEPTH times in a generate loop.
- Forwarding priority mux and popcount live in the top level.

## Test plan
- Reset: assert rst_n=0 mid-stream with 2 valid entries -> all outputs 0 and inflight=0 immediately, without waiting for a clock.
- Latency, DEPTH=2: write rd=5, data=0xDEADBEEF at edge 0 -> wb_regwrite=1, wb_rd=5, wb_data=0xDEADBEEF after edge 1 for exactly one cycle.
- $zero: mem_regwrite=1, rd=0 -> inflight stays 0, wb_regwrite never asserts, fwd_rs=0 gives fwd_hit=0.
- Pause: entry at stage DEPTH-1, pause held 3 cycles -> wb_regwrite=0 for those cycles, then 1 for one cycle after release, with data unchanged.
- Flush with pause: 2 entries in flight, pause=1 and flush=1 together -> next cycle inflight=0; no write ever commits.
- Forwarding: rd=7 data=0x11 then rd=7 data=0x22 on consecutive cycles, fwd_rs=7 -> fwd_hit=1, fwd_data=0x22; commits are 0x11 then 0x22.
